// File: rtl/piso_out.sv
// piso_out: parallel-in/serial-out stage feeding the 16-to-8 data converter.
// Captures N_WORDS 16-bit words on load and emits them as bytes, MSB byte
// first. trig leads the byte stream by one cycle because the converter
// registers trig once before using it to qualify its byte input.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for load; out/trig/busy/done low
// S_LEAD  | trig high one cycle ahead of the first byte
// S_SHIFT | one byte per enabled cycle; trig drops with the last byte
module piso_out #(
  parameter int N_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic [16*N_WORDS-1:0]  din,
  output logic [7:0]             out,
  output logic                   trig,
  output logic                   busy,
  output logic                   done
);

  localparam int N_BYTES = 2 * N_WORDS;
  localparam int CW      = $clog2(N_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  localparam logic [CW-1:0] LAST_BYTE = CW'(N_BYTES - 1);

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [8*N_BYTES-1:0] sbuf;
  logic [8*N_BYTES-1:0] din_bytes;

  // Reorder din so that the byte to be sent first sits at sbuf[7:0]:
  // byte 2i is the MSB of word i, byte 2i+1 its LSB.
  always_comb begin
    din_bytes = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      din_bytes[16*i     +: 8] = din[16*i + 8 +: 8];
      din_bytes[16*i + 8 +: 8] = din[16*i     +: 8];
    end
  end

  assign cnt_nxt = cnt + 1'b1;

  // Sequencer, shift buffer and registered outputs; enable=0 freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      sbuf  <= '0;
      out   <= '0;
      trig  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          out  <= '0;
          trig <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (load) begin
            sbuf  <= din_bytes;
            busy  <= 1'b1;
            trig  <= 1'b1;
            state <= S_LEAD;
          end
        end
        S_LEAD: begin
          out   <= sbuf[7:0];
          sbuf  <= sbuf >> 8;
          cnt   <= '0;
          trig  <= 1'b1;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == LAST_BYTE) begin
            // Last byte has been on out for one cycle; close the frame.
            out   <= '0;
            trig  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            out  <= sbuf[7:0];
            sbuf <= sbuf >> 8;
            cnt  <= cnt_nxt;
            trig <= (cnt_nxt != LAST_BYTE);
            done <= (cnt_nxt == LAST_BYTE);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
